// File: rtl/nibble_sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package nibble_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int nib_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_sub_cla4_slice.sv
// 4-bit generate/propagate carry-lookahead adder slice, purely combinational.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = x & y;
  assign p = x ^ y;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_sub.sv
// Nibble-serial two's-complement subtractor: diff = a - b - bin, one CLA slice per clock.
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | computing nibble k through the shared slice
// DONE  | result held, out_valid high until out_ready
module nibble_serial_sub
  import nibble_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NIB = nib_count(WIDTH);
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t state;
  state_t state_nx;

  logic [KW-1:0]                  k;
  logic                           carry;
  logic [NIB-1:0][SLICE_W-1:0]    a_q;
  logic [NIB-1:0][SLICE_W-1:0]    b_q;
  logic [NIB-1:0][SLICE_W-1:0]    diff_q;
  logic [SLICE_W-1:0]             x;
  logic [SLICE_W-1:0]             y;
  logic [SLICE_W-1:0]             s;
  logic                           cout;
  logic                           accept;
  logic                           last;

  assign accept = in_valid && in_ready;
  assign last   = (k == KW'(NIB - 1));
  assign x      = a_q[k];
  assign y      = ~b_q[k];
  assign diff   = diff_q;

  cla4_slice u_slice (
    .x    (x),
    .y    (y),
    .cin  (carry),
    .s    (s),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Subtraction as a + ~b + ~bin; the final carry is the inverted borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k      <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      carry <= ~bin;
      k     <= '0;
    end else if (state == BUSY) begin
      diff_q[k] <= s;
      carry     <= cout;
      k         <= last ? '0 : k + KW'(1);
      if (last) begin
        bout <= ~cout;
        ovf  <= (a_q[NIB-1][SLICE_W-1] != b_q[NIB-1][SLICE_W-1]) &&
                (s[SLICE_W-1] != a_q[NIB-1][SLICE_W-1]);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed self-checking bench for nibble_serial_sub at WIDTH=16.
module tb_nibble_serial_sub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int tests;
  int fails;

  nibble_serial_sub #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                          input string tag);
    @(negedge clk);
    a        = ta;
    b        = tb_v;
    bin      = tbin;
    in_valid = 1'b1;
    check({31'd0, in_ready}, 32'd1, {tag, "_ready_idle"});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({31'd0, in_ready}, 32'd0, {tag, "_ready_busy"});
  endtask

  task automatic wait_result(input logic [15:0] ed, input logic eb, input logic eo,
                             input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(n, 4, {tag, "_latency"});
    check({16'd0, diff}, {16'd0, ed}, {tag, "_diff"});
    check({31'd0, bout}, {31'd0, eb}, {tag, "_bout"});
    check({31'd0, ovf}, {31'd0, eo}, {tag, "_ovf"});
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({31'd0, out_valid}, 32'd0, {tag, "_valid_drop"});
    check({31'd0, in_ready}, 32'd1, {tag, "_back_idle"});
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check({16'd0, diff}, 32'd0, "rst_diff");
    check({31'd0, bout}, 32'd0, "rst_bout");
    check({31'd0, ovf}, 32'd0, "rst_ovf");
    check({31'd0, out_valid}, 32'd0, "rst_valid");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({31'd0, in_ready}, 32'd1, "rst_ready");

    start_op(16'h1234, 16'h0234, 1'b0, "basic");
    wait_result(16'h1000, 1'b0, 1'b0, "basic");
    release_result("basic");

    start_op(16'h0000, 16'h0001, 1'b0, "ripple");
    wait_result(16'hFFFF, 1'b1, 1'b0, "ripple");
    release_result("ripple");

    // out_ready held high before DONE must not shorten the operation
    @(negedge clk);
    out_ready = 1'b1;
    start_op(16'h8000, 16'h0001, 1'b0, "ovf_neg");
    wait_result(16'h7FFF, 1'b0, 1'b1, "ovf_neg");
    @(posedge clk);
    #1;
    check({31'd0, out_valid}, 32'd0, "ovf_neg_one_cycle");
    out_ready = 1'b0;

    start_op(16'h7FFF, 16'hFFFF, 1'b0, "ovf_pos");
    wait_result(16'h8000, 1'b1, 1'b1, "ovf_pos");
    release_result("ovf_pos");

    start_op(16'h0005, 16'h0005, 1'b1, "bin");
    wait_result(16'hFFFF, 1'b1, 1'b0, "bin");
    release_result("bin");

    start_op(16'h00FF, 16'h0F00, 1'b0, "bp");
    wait_result(16'hF1FF, 1'b1, 1'b0, "bp");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a        = 16'h1111;
      b        = 16'h0001;
      bin      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check({31'd0, out_valid}, 32'd1, "bp_valid_hold");
      check({31'd0, in_ready}, 32'd0, "bp_ready_low");
      check({16'd0, diff}, 32'h0000F1FF, "bp_diff_stable");
      check({30'd0, bout, ovf}, 32'd2, "bp_flags_stable");
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result("bp");
    repeat (2) @(posedge clk);
    #1;
    check({31'd0, out_valid}, 32'd0, "bp_not_taken");
    check({16'd0, diff}, 32'h0000F1FF, "bp_diff_kept");

    start_op(16'h0003, 16'h0001, 1'b0, "after_bp");
    wait_result(16'h0002, 1'b0, 1'b0, "after_bp");
    release_result("after_bp");

    // Abort mid-computation; leave nonzero flags behind first
    start_op(16'h0000, 16'h0001, 1'b0, "pre_abort");
    wait_result(16'hFFFF, 1'b1, 1'b0, "pre_abort");
    release_result("pre_abort");
    start_op(16'hFFFF, 16'h0001, 1'b0, "abort");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check({16'd0, diff}, 32'd0, "abort_diff");
    check({31'd0, bout}, 32'd0, "abort_bout");
    check({31'd0, ovf}, 32'd0, "abort_ovf");
    check({31'd0, out_valid}, 32'd0, "abort_valid");
    check({31'd0, in_ready}, 32'd1, "abort_idle");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check({31'd0, out_valid}, 32'd0, "abort_no_result");

    start_op(16'h0010, 16'h0001, 1'b0, "post_abort");
    wait_result(16'h000F, 1'b0, 1'b0, "post_abort");
    release_result("post_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
